// File: rtl/syscall_input_unit.sv
// Input-side syscall engine: read_int (5), read_string (8), read_char (12).
// Optional build macro SYSCALL_INPUT_NEG_EN accepts a leading '-' in read_int.
module syscall_input_unit #(
    parameter logic [31:0] SYSCALL_INST = 32'h0000000C,
    parameter logic [7:0]  NEWLINE      = 8'h0A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        stall,
    output logic        mem_store_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        v0_write,
    output logic [31:0] v0_result
);

    typedef enum logic [2:0] {
        IDLE,
        RD_INT,
        RD_STR,
        STR_TERM,
        RD_CHAR,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] base;
    logic [31:0] len;
    logic [31:0] cnt;
    logic [31:0] acc;
`ifdef SYSCALL_INPUT_NEG_EN
    logic        neg;
    logic        seen_digit;
`endif

    logic        code_int;
    logic        code_str;
    logic        code_char;
    logic        trigger;
    logic        accept;
    logic        is_digit;
    logic        is_nl;
    logic [31:0] digit;
    logic [31:0] acc_next;
    logic [31:0] int_result;

    assign code_int  = (v0 == 32'd5);
    assign code_str  = (v0 == 32'd8);
    assign code_char = (v0 == 32'd12);

    // Reset gating keeps stall at 0 while reset is held.
    assign trigger = !reset && (inst == SYSCALL_INST) && (state == IDLE)
                     && (code_int || code_str || code_char);

    assign stall    = trigger || (state != IDLE);
    assign rx_ready = (state == RD_INT) || (state == RD_STR)
                      || (state == RD_CHAR);
    assign accept   = rx_valid && rx_ready;

    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_nl    = (rx_data == NEWLINE);
    assign digit    = {24'b0, rx_data - 8'h30};
    assign acc_next = (acc * 32'd10) + digit;

`ifdef SYSCALL_INPUT_NEG_EN
    assign int_result = neg ? (~acc + 32'd1) : acc;
`else
    assign int_result = acc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            base           <= '0;
            len            <= '0;
            cnt            <= '0;
            acc            <= '0;
            mem_store_byte <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            v0_write       <= 1'b0;
            v0_result      <= '0;
`ifdef SYSCALL_INPUT_NEG_EN
            neg            <= 1'b0;
            seen_digit     <= 1'b0;
`endif
        end else begin
            mem_store_byte <= 1'b0;
            v0_write       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        base <= a0;
                        len  <= a1;
                        cnt  <= '0;
                        acc  <= '0;
`ifdef SYSCALL_INPUT_NEG_EN
                        neg        <= 1'b0;
                        seen_digit <= 1'b0;
`endif
                        unique case (1'b1)
                            code_int:  state <= RD_INT;
                            code_char: state <= RD_CHAR;
                            default: begin
                                if (a1 == 32'd0)
                                    state <= DONE;
                                else if (a1 == 32'd1)
                                    state <= STR_TERM;
                                else
                                    state <= RD_STR;
                            end
                        endcase
                    end
                end
                RD_INT: begin
                    if (accept) begin
                        if (is_nl) begin
                            v0_write  <= 1'b1;
                            v0_result <= int_result;
                            state     <= DONE;
                        end else if (is_digit) begin
                            acc <= acc_next;
`ifdef SYSCALL_INPUT_NEG_EN
                            seen_digit <= 1'b1;
                        end else if (rx_data == 8'h2D && !seen_digit) begin
                            neg <= 1'b1;
`endif
                        end
                    end
                end
                RD_STR: begin
                    if (accept) begin
                        mem_store_byte <= 1'b1;
                        mem_addr       <= base + cnt;
                        mem_wdata      <= {24'b0, rx_data};
                        cnt            <= cnt + 32'd1;
                        // Reserve the last slot of the buffer for the NUL.
                        if (is_nl || (cnt + 32'd1 == len - 32'd1))
                            state <= STR_TERM;
                    end
                end
                STR_TERM: begin
                    mem_store_byte <= 1'b1;
                    mem_addr       <= base + cnt;
                    mem_wdata      <= '0;
                    state          <= DONE;
                end
                RD_CHAR: begin
                    if (accept) begin
                        v0_write  <= 1'b1;
                        v0_result <= {24'b0, rx_data};
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_input_unit.sv
// Bench for syscall_input_unit: vector table plus hand-written sequences,
// with a write scoreboard fed by a reference model of the string path.
module tb_syscall_input_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic [31:0] v0;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        stall;
    logic        mem_store_byte;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        v0_write;
    logic [31:0] v0_result;

    syscall_input_unit dut (
        .clk(clk),
        .reset(reset),
        .inst(inst),
        .v0(v0),
        .a0(a0),
        .a1(a1),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .stall(stall),
        .mem_store_byte(mem_store_byte),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .v0_write(v0_write),
        .v0_result(v0_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] code;
        logic [31:0] base;
        logic [31:0] blen;
        int          n;
        logic [7:0]  b[12];
        logic [31:0] res;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    vec_t        vecs[12];
    vec_t        cur;
    wr_t         exp_q[$];
    int          n_vec = 0;
    int          errs = 0;
    int          vw_cnt = 0;
    logic [31:0] last_res = '0;
    int          accepted = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void set_vec(input int i, input logic [31:0] code,
                                    input logic [31:0] base,
                                    input logic [31:0] blen,
                                    input string s, input logic [31:0] res);
        vecs[i].code = code;
        vecs[i].base = base;
        vecs[i].blen = blen;
        vecs[i].n    = s.len();
        vecs[i].res  = res;
        for (int k = 0; k < 12; k++)
            vecs[i].b[k] = (k < s.len()) ? s[k] : 8'h00;
    endfunction

    always begin
        @(negedge clk);
        #1;
        if (mem_store_byte) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", mem_addr, 32'hxxxxxxxx);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, {24'b0, e.data});
            end
        end
        if (v0_write) begin
            vw_cnt++;
            last_res = v0_result;
            chk("stall_in_done", {31'b0, stall}, 32'd1);
        end
    end

    // Reference: which bytes get accepted and which writes appear.
    function automatic int model(input vec_t v);
        int          na;
        logic [31:0] c;
        na = 0;
        if (v.code == 32'd5) begin
            for (int i = 0; i < v.n; i++) begin
                na++;
                if (v.b[i] == 8'h0A) break;
            end
        end else if (v.code == 32'd12) begin
            na = (v.n > 0) ? 1 : 0;
        end else if (v.code == 32'd8 && v.blen != 0) begin
            c = 0;
            for (int i = 0; i < v.n && c < v.blen - 1; i++) begin
                exp_q.push_back({v.base + c, v.b[i]});
                c++;
                na++;
                if (v.b[i] == 8'h0A) break;
            end
            exp_q.push_back({v.base + c, 8'h00});
        end
        return na;
    endfunction

    task automatic trigger(input logic [31:0] code, input logic [31:0] base,
                           input logic [31:0] blen);
        logic exp_stall;
        exp_stall = (code == 5 || code == 8 || code == 12);
        @(negedge clk);
        inst = 32'h0000000C;
        v0   = code;
        a0   = base;
        a1   = blen;
        #1;
        chk("trigger_stall", {31'b0, stall}, {31'b0, exp_stall});
        @(posedge clk);
        #1;
        inst     = '0;
        v0       = '0;
        rx_valid = 1'b0;
    endtask

    task automatic send(input bit gap);
        bit stop;
        bit got;
        accepted = 0;
        stop = 0;
        for (int i = 0; i < cur.n && !stop; i++) begin
            rx_data  = cur.b[i];
            rx_valid = 1'b1;
            got = 0;
            for (int k = 0; k < 40 && !got && !stop; k++) begin
                @(negedge clk);
                if (rx_ready) begin
                    @(posedge clk);
                    #1;
                    accepted++;
                    got = 1;
                end else if (!stall) begin
                    stop = 1;
                end
            end
            if (!got && !stop) chk("byte_timeout", 32'd0, 32'd1);
            if (gap && got) begin
                rx_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic finish_op(input int exp_acc, input bit exp_vw);
        bit done;
        done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            #1;
            if (!stall) done = 1;
        end
        chk("op_finish", {31'b0, done}, 32'd1);
        chk("accepted", accepted, exp_acc);
        chk("v0_write_cnt", vw_cnt, exp_vw ? 32'd1 : 32'd0);
        if (exp_vw) chk("v0_result", last_res, cur.res);
        chk("writes_left", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input bit gap);
        int  na;
        bit  vw;
        cur = v;
        vw_cnt = 0;
        last_res = '0;
        na = model(v);
        vw = (v.code == 32'd5) || (v.code == 32'd12);
        trigger(v.code, v.base, v.blen);
        send(gap);
        finish_op(na, vw);
    endtask

    initial begin
        vec_t hv;
        reset    = 1'b1;
        inst     = '0;
        v0       = '0;
        a0       = '0;
        a1       = '0;
        rx_data  = '0;
        rx_valid = 1'b0;

        set_vec(0, 5, 0, 0, "123\n", 32'd123);
        set_vec(1, 8, 32'h100, 8, "hi\n", 0);
        set_vec(2, 8, 32'h200, 3, "abcd", 0);
        set_vec(3, 8, 32'h300, 0, "x", 0);
        set_vec(4, 8, 32'h400, 1, "q", 0);
        set_vec(5, 12, 0, 0, "Z", 32'h5A);
`ifdef SYSCALL_INPUT_NEG_EN
        set_vec(6, 5, 0, 0, "-12\n", 32'hFFFFFFF4);
`else
        set_vec(6, 5, 0, 0, "-12\n", 32'd12);
`endif
        set_vec(7, 5, 0, 0, "4294967297\n", 32'd1);
        set_vec(8, 8, 32'hFFFFFFFE, 4, "xyz", 0);
        set_vec(9, 5, 0, 0, "a7b\n", 32'd7);
        set_vec(10, 4, 0, 0, "5\n", 0);
        set_vec(11, 5, 0, 0, "1-2\n", 32'd12);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("rst_store", {31'b0, mem_store_byte}, 32'd0);
        chk("rst_v0_write", {31'b0, v0_write}, 32'd0);
        chk("rst_v0_result", v0_result, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0);

        // read_char with rx_valid gaps; a byte held on the trigger edge
        // must not be taken.
        set_vec(0, 12, 0, 0, "Z", 32'h5A);
        cur = vecs[0];
        vw_cnt = 0;
        @(negedge clk);
        rx_data  = 8'h51;
        rx_valid = 1'b1;
        trigger(12, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        send(1'b1);
        finish_op(1, 1'b1);

        set_vec(1, 5, 0, 0, "98\n", 32'd98);
        run_vec(vecs[1], 1'b1);

        // Reset in the middle of read_int.
        set_vec(2, 5, 0, 0, "45", 0);
        cur = vecs[2];
        vw_cnt = 0;
        trigger(5, 0, 0);
        send(1'b0);
        chk("mid_accepted", accepted, 32'd2);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);
        chk("mid_rst_ready", {31'b0, rx_ready}, 32'd0);
        chk("mid_rst_store", {31'b0, mem_store_byte}, 32'd0);
        chk("mid_rst_v0w", {31'b0, v0_write}, 32'd0);
        chk("mid_rst_v0r", v0_result, 32'd0);
        reset = 1'b0;
        chk("mid_rst_no_v0w", vw_cnt, 32'd0);
        set_vec(3, 5, 0, 0, "7\n", 32'd7);
        run_vec(vecs[3], 1'b0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
        $finish;
    end

endmodule
